// File: rtl/rs_age_station.sv
// rs_age_station: reservation station in front of one ALU issue port.
// It holds up to DEPTH waiting ALU operations and captures operand values from
// N_WAKE tag-broadcast ports. Each cycle it offers at most one operand-complete
// entry through a valid/ready handshake.
// Optional feature macro: RS_AGE_ORDER_EN. When defined, a DEPTH x DEPTH age
// matrix selects the oldest ready entry. When undefined, the lowest-index ready
// entry is selected.
module rs_age_station #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32,
  parameter int N_WAKE = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    disp_valid_in,
  input  logic [6:0]              disp_type_in,
  input  logic [3:0]              disp_op_in,
  input  logic [TAG_W-1:0]        disp_tag_in,
  input  logic [XLEN-1:0]         disp_v1_in,
  input  logic [XLEN-1:0]         disp_v2_in,
  input  logic [XLEN-1:0]         disp_imm_in,
  input  logic                    disp_use_imm_in,
  input  logic                    disp_dep1_valid_in,
  input  logic                    disp_dep2_valid_in,
  input  logic [TAG_W-1:0]        disp_dep1_in,
  input  logic [TAG_W-1:0]        disp_dep2_in,
  output logic                    full_out,
  output logic [$clog2(DEPTH):0]  count_out,
  input  logic [N_WAKE-1:0]       wk_valid_in,
  input  logic [N_WAKE*TAG_W-1:0] wk_tag_in,
  input  logic [N_WAKE*XLEN-1:0]  wk_value_in,
  output logic                    iss_valid_out,
  input  logic                    iss_ready_in,
  output logic [TAG_W-1:0]        iss_tag_out,
  output logic [6:0]              iss_type_out,
  output logic [3:0]              iss_op_out,
  output logic [XLEN-1:0]         iss_v1_out,
  output logic [XLEN-1:0]         iss_v2_out
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Fields that are written only at allocation and never change afterwards.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [6:0]       typ;
    logic [3:0]       op;
    logic             use_imm;
    logic [XLEN-1:0]  imm;
  } payload_t;

  // Result of searching the broadcast ports for one producer tag.
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] val;
  } wake_t;

  // Scans downwards so that the lowest matching port index wins.
  function automatic wake_t wake_lookup(
    input logic [TAG_W-1:0]        tag,
    input logic [N_WAKE-1:0]       vld,
    input logic [N_WAKE*TAG_W-1:0] tags,
    input logic [N_WAKE*XLEN-1:0]  vals
  );
    wake_t r;
    r.hit = 1'b0;
    r.val = '0;
    for (int k = N_WAKE - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        r.hit = 1'b1;
        r.val = vals[k*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  // Control state: reset.
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] pend1_q, pend1_d;
  logic [DEPTH-1:0] pend2_q, pend2_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Datapath state: not reset, and only meaningful while the entry is busy.
  logic [TAG_W-1:0] dep1_q [DEPTH];
  logic [TAG_W-1:0] dep1_d [DEPTH];
  logic [TAG_W-1:0] dep2_q [DEPTH];
  logic [TAG_W-1:0] dep2_d [DEPTH];
  logic [XLEN-1:0]  v1_q   [DEPTH];
  logic [XLEN-1:0]  v1_d   [DEPTH];
  logic [XLEN-1:0]  v2_q   [DEPTH];
  logic [XLEN-1:0]  v2_d   [DEPTH];
  payload_t         pay_q  [DEPTH];
  payload_t         pay_d  [DEPTH];

`ifdef RS_AGE_ORDER_EN
  // Row i bit j set: entry i is older than entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] older_ready;
`endif

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] alloc_oh;
  logic             full;
  logic             disp_acc;
  logic             issue_fire;
  wake_t            wk1 [DEPTH];
  wake_t            wk2 [DEPTH];
  wake_t            byp1;
  wake_t            byp2;

  assign ready      = busy_q & ~pend1_q & ~pend2_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign disp_acc   = disp_valid_in && !full;
  assign byp1       = wake_lookup(disp_dep1_in, wk_valid_in, wk_tag_in, wk_value_in);
  assign byp2       = wake_lookup(disp_dep2_in, wk_valid_in, wk_tag_in, wk_value_in);

  assign full_out      = full;
  assign count_out     = count_q;
  assign iss_valid_out = rdy_in && (|sel_oh);
  assign issue_fire    = iss_valid_out && iss_ready_in;

  // Per-entry wakeup match against the registered producer tags.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wk1[e] = wake_lookup(dep1_q[e], wk_valid_in, wk_tag_in, wk_value_in);
      wk2[e] = wake_lookup(dep2_q[e], wk_valid_in, wk_tag_in, wk_value_in);
    end
  end

  // Allocation target: the lowest-index free entry.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    alloc_oh = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (!busy_q[e]) begin
        alloc_oh    = '0;
        alloc_oh[e] = 1'b1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Issue select: the ready entry that no other ready entry is older than.
  always_comb begin
    older_ready = '0;
    sel_oh      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_ready[i] = older_ready[i] | (ready[j] & age_q[j][i]);
      end
      sel_oh[i] = ready[i] && !older_ready[i];
    end
  end
`else
  // Issue select: the lowest-index ready entry.
  always_comb begin
    sel_oh = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (ready[e]) begin
        sel_oh    = '0;
        sel_oh[e] = 1'b1;
      end
    end
  end
`endif

  // Issue datapath: a one-hot mux over registered state only.
  always_comb begin
    iss_tag_out  = '0;
    iss_type_out = '0;
    iss_op_out   = '0;
    iss_v1_out   = '0;
    iss_v2_out   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (rdy_in && sel_oh[e]) begin
        iss_tag_out  = pay_q[e].tag;
        iss_type_out = pay_q[e].typ;
        iss_op_out   = pay_q[e].op;
        iss_v1_out   = v1_q[e];
        iss_v2_out   = pay_q[e].use_imm ? pay_q[e].imm : v2_q[e];
      end
    end
  end

  // Next-state: hold, flush, or wakeup + issue + dispatch.
  always_comb begin
    busy_d  = busy_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    count_d = count_q;
    dep1_d  = dep1_q;
    dep2_d  = dep2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    pay_d   = pay_q;
`ifdef RS_AGE_ORDER_EN
    age_d   = age_q;
`endif
    if (rdy_in) begin
      if (flush_in) begin
        busy_d  = '0;
        count_d = '0;
      end else begin
        // Operand capture for entries already waiting.
        for (int e = 0; e < DEPTH; e++) begin
          if (busy_q[e] && pend1_q[e] && wk1[e].hit) begin
            pend1_d[e] = 1'b0;
            v1_d[e]    = wk1[e].val;
          end
          if (busy_q[e] && pend2_q[e] && wk2[e].hit) begin
            pend2_d[e] = 1'b0;
            v2_d[e]    = wk2[e].val;
          end
          if (issue_fire && sel_oh[e]) begin
            busy_d[e] = 1'b0;
          end
        end
        // New entry, with same-cycle broadcast bypass on each operand.
        if (disp_acc) begin
          for (int e = 0; e < DEPTH; e++) begin
            if (alloc_oh[e]) begin
              busy_d[e]  = 1'b1;
              dep1_d[e]  = disp_dep1_in;
              dep2_d[e]  = disp_dep2_in;
              pend1_d[e] = disp_dep1_valid_in && !byp1.hit;
              pend2_d[e] = disp_dep2_valid_in && !byp2.hit;
              v1_d[e]    = (disp_dep1_valid_in && byp1.hit) ? byp1.val : disp_v1_in;
              v2_d[e]    = (disp_dep2_valid_in && byp2.hit) ? byp2.val : disp_v2_in;
              pay_d[e].tag     = disp_tag_in;
              pay_d[e].typ     = disp_type_in;
              pay_d[e].op      = disp_op_in;
              pay_d[e].use_imm = disp_use_imm_in;
              pay_d[e].imm     = disp_imm_in;
`ifdef RS_AGE_ORDER_EN
              // The newcomer is younger than everything already present.
              age_d[e] = '0;
              for (int b = 0; b < DEPTH; b++) begin
                if (busy_q[b]) age_d[b][e] = 1'b1;
              end
`endif
            end
          end
        end
        count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue_fire);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n_in) begin
      busy_q  <= '0;
      pend1_q <= '0;
      pend2_q <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      count_q <= count_d;
    end
  end

  // Entry datapath storage.
  always_ff @(posedge clk_in) begin
    // NOTE: the operand/payload arrays are deliberately not reset; busy and
    // pend gate every use, and leaving them unreset keeps them as plain storage.
    dep1_q <= dep1_d;
    dep2_q <= dep2_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    pay_q  <= pay_d;
  end

`ifdef RS_AGE_ORDER_EN
  // Age matrix register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

endmodule

// File: doc/rs_age_station.md
# rs_age_station

Parametrised reservation station for the out-of-order core. It sits between instruction dispatch and one ALU issue port. It holds up to DEPTH waiting ALU operations and captures operand values from N_WAKE tag-broadcast ports (CDB, load/store CDB, ROB and register-file forwarding). Each cycle it issues at most one operand-complete entry, oldest first, through a valid/ready handshake.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- DEPTH, 16: entry count, power of two, 2..64.
- TAG_W, 5: ROB tag width.
- XLEN, 32: operand width.
- N_WAKE, 5: number of wakeup broadcast ports.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global pause; low freezes all state.
- flush_in  in  1  synchronous clear of all entries (mispredict).
- disp_valid_in  in  1  dispatch request.
- disp_type_in  in  7  opcode class.
- disp_op_in  in  4  ALU sub-op.
- disp_tag_in  in  TAG_W  destination ROB tag.
- disp_v1_in, disp_v2_in, disp_imm_in  in  XLEN  operand 1, operand 2 and immediate.
- disp_use_imm_in  in  1  issue imm instead of v2.
- disp_dep1_valid_in, disp_dep2_valid_in  in  1  operand still pending.
- disp_dep1_in, disp_dep2_in  in  TAG_W  producer tags.
- full_out  out  1  count == DEPTH.
- count_out  out  $clog2(DEPTH)+1  occupied entries.
- wk_valid_in  in  N_WAKE  per-port broadcast valid.
- wk_tag_in  in  N_WAKE*TAG_W  port k at bits [k*TAG_W +: TAG_W].
- wk_value_in  in  N_WAKE*XLEN  port k at bits [k*XLEN +: XLEN].
- iss_valid_out  out  1  an entry is offered.
- iss_ready_in  in  1  ALU accepts.
- iss_tag_out  out  TAG_W  ROB tag of the offered entry.
- iss_type_out  out  7  opcode class.
- iss_op_out  out  4  ALU sub-op.
- iss_v1_out, iss_v2_out  out  XLEN  operands; v2 = use_imm ? imm : captured v2.

## Operation
- Each entry holds: busy, payload, v1, v2, imm, use_imm, pend1, pend2, dep1, dep2. Tag 0 is a legal tag; pending state is tracked only by the pend bits.
- Allocation: the lowest-index free entry.
- Dispatch bypass: if a wakeup port matches a dispatched dep in the same cycle, the entry is written with the value and its pend bit cleared.
- Dispatch while full_out=1 is dropped and count is unchanged.
- Wakeup:
  - Each busy entry with pendX=1 and depX equal to wk_tag of a valid port captures that port's value and clears pendX.
  - Both operands can wake in the same cycle.
  - If several ports match, the lowest port index wins.
- Ready = busy & !pend1 & !pend2, evaluated on registered state.
- Select: the oldest ready entry, using a DEPTH×DEPTH age matrix. Row i bit j = entry i older than entry j.
  - On allocation, the new entry's row is cleared and its column is set for all busy entries.
- Issue fires when iss_valid_out && iss_ready_in. The selected entry's busy bit clears at the edge.
- Outputs are combinational from registers; there is no combinational path from the wakeup inputs to the iss_* outputs.
- count update, with d = dispatch accepted and i = issue fired: count' = count + d - i. Dispatch and issue in the same cycle leave count unchanged.
- Dispatch is accepted only when count < DEPTH at that edge. An issue in the same cycle does not free space for that cycle's dispatch.
- Priority: reset > !rdy_in (hold) > flush_in > normal operation.
  - flush_in clears every busy bit and count.
  - A same-cycle dispatch and issue are both discarded; iss_valid_out is still driven that cycle and the ALU must also honour the flush.

## Timing
- Reset values: all busy=0, pend=0, age matrix=0, count_out=0, full_out=0, iss_valid_out=0, all iss_* data=0.
- Reset asserted mid-operation clears state immediately (asynchronous).
- Dispatch at edge t with no pending deps: eligible for issue in the cycle after t.
- Wakeup at edge t: the entry can offer in the cycle after t.
- Back-to-back issue: one per cycle when the ALU holds iss_ready_in high.
- iss_* outputs are held stable while iss_valid_out=1 && iss_ready_in=0, unless an older entry becomes ready. Re-selection of an older entry is permitted.
- rdy_in=0: no state changes; iss_valid_out=0.

## Configuration
- RS_AGE_ORDER_EN defined: oldest-first select via the age matrix, as above.
- RS_AGE_ORDER_EN undefined: the age matrix is not built; select is the lowest-index ready entry. All other behaviour is identical.

## Test plan
- Dispatch tag 3, no deps, v1=5, v2=7, use_imm=0 -> next cycle iss_valid_out=1, tag 3, v1=5, v2=7; count goes 1 -> 0 after ALU accept.
- Dispatch A (dep1=tag 0 pending) into entry 0; wake port 2 broadcasts tag 0, value 0xAA -> next cycle A issues with v1=0xAA (tag-0 correctness).
- Fill DEPTH entries -> full_out=1; extra dispatch dropped, count stays DEPTH; one issue -> count DEPTH-1, full_out=0.
- Entries in slots 5 (older) and 2 (younger) become ready in the same cycle -> with RS_AGE_ORDER_EN slot 5 issues first; without it slot 2 issues first.
- Dispatch with dep2=9 while port 0 broadcasts tag 9, value 0x1234 in the same cycle -> entry is ready the next cycle, v2=0x1234.
- flush_in with 4 busy entries and a simultaneous dispatch -> count_out=0 and iss_valid_out=0 next cycle; rdy_in=0 for 3 cycles holds all state unchanged.
